// File: rtl/spmv_row_mac_if.sv
// Stream bundle for the SpMV row MAC: row-length stream, element stream and row-result stream.
// The slave modport is the MAC block's view; master is the producer/consumer side.
interface spmv_row_mac_if #(
  parameter int DW    = 32,
  parameter int LW    = 16,
  parameter int ACC_W = 64
);
  logic             len_valid;
  logic             len_ready;
  logic [LW-1:0]    len_data;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             y_valid;
  logic             y_ready;
  logic [ACC_W-1:0] y_data;
  logic [LW-1:0]    y_row;

  modport master (
    output len_valid, len_data, in_valid, in_data, y_ready,
    input  len_ready, in_ready, y_valid, y_data, y_row
  );

  modport slave (
    input  len_valid, len_data, in_valid, in_data, y_ready,
    output len_ready, in_ready, y_valid, y_data, y_row
  );
endinterface

// File: rtl/spmv_row_mac.sv
// CSR row multiply-accumulate: consumes (x, A) word pairs per non-zero, sums them per row
// and emits one y[row] result per row of the job.
module spmv_row_mac #(
  parameter int DW     = 32,
  parameter int LW     = 16,
  parameter int ACC_W  = 64,   // must be >= 2*DW
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LW-1:0]      num_rows,
  spmv_row_mac_if.slave      bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, GET_LEN, GET_V, GET_M, MAC, EMIT, DONE
  } state_t;

  state_t           state;
  logic [LW-1:0]    num_q;
  logic [LW-1:0]    row_cnt;
  logic [LW-1:0]    remaining;
  logic [DW-1:0]    x;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod;
  logic             len_ready_q;
  logic             in_ready_q;
  logic             y_valid_q;
  logic [ACC_W-1:0] y_data_q;
  logic [LW-1:0]    y_row_q;
  logic             busy_q;
  logic             done_q;

  logic [2*DW-1:0]  mul_s;
  logic [2*DW-1:0]  mul_u;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [LW-1:0]    row_next;

  // Full-width product; the extension to ACC_W follows the operand signedness.
  assign mul_s    = $signed(x) * $signed(bus.in_data);
  assign mul_u    = x * bus.in_data;
  assign prod_ext = SIGNED ? ACC_W'($signed(mul_s)) : ACC_W'(mul_u);
  assign acc_sum  = acc + prod;
  assign row_next = row_cnt + LW'(1);

  assign bus.len_ready = len_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.y_data    = y_data_q;
  assign bus.y_row     = y_row_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Ready flags are updated together with the state, so each one tracks exactly one
  // state and a plain valid test in that state is a completed handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      num_q       <= '0;
      row_cnt     <= '0;
      remaining   <= '0;
      x           <= '0;
      acc         <= '0;
      prod        <= '0;
      len_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      y_valid_q   <= 1'b0;
      y_data_q    <= '0;
      y_row_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_q   <= num_rows;
            row_cnt <= '0;
            acc     <= '0;
            y_row_q <= '0;
            if (num_rows == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state       <= GET_LEN;
              len_ready_q <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
            end
          end
        end
        GET_LEN: begin
          if (bus.len_valid) begin
            remaining   <= bus.len_data;
            acc         <= '0;
            len_ready_q <= 1'b0;
            if (bus.len_data == '0) begin
              state     <= EMIT;
              y_data_q  <= '0;
              y_valid_q <= 1'b1;
            end else begin
              state      <= GET_V;
              in_ready_q <= 1'b1;
            end
          end
        end
        GET_V: begin
          if (bus.in_valid) begin
            x     <= bus.in_data;
            state <= GET_M;
          end
        end
        GET_M: begin
          if (bus.in_valid) begin
            prod       <= prod_ext;
            in_ready_q <= 1'b0;
            state      <= MAC;
          end
        end
        MAC: begin
          acc       <= acc_sum;
          remaining <= remaining - LW'(1);
          if (remaining == LW'(1)) begin
            state     <= EMIT;
            y_data_q  <= acc_sum;
            y_valid_q <= 1'b1;
          end else begin
            state      <= GET_V;
            in_ready_q <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.y_ready) begin
            y_valid_q <= 1'b0;
            row_cnt   <= row_next;
            if (row_next == num_q) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              y_row_q     <= row_next;
              state       <= GET_LEN;
              len_ready_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_mac.sv
// Directed bench: a signed and an unsigned instance run the same vectors in lockstep and are
// checked against hand-computed row results, plus reset, empty-job and back-pressure sequences.
module tb_spmv_row_mac;

  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int ACC_W = 64;

  typedef struct {
    int                 len;
    logic [3:0][31:0]   w;
    logic [63:0]        exp_s;
    logic [63:0]        exp_u;
    bit                 gaps;
    int                 stall;
    bit                 no_in;
  } row_vec_t;

  typedef struct {
    int first;
    int n;
  } job_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] num_rows = '0;
  logic          len_valid = 1'b0;
  logic [LW-1:0] len_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          y_ready = 1'b0;
  logic          busy_s, done_s, busy_u, done_u;

  int checks = 0;
  int failures = 0;
  bit watch_in = 1'b0;
  int in_hi = 0;

  row_vec_t tbl [8];
  job_t     jobs [4];

  spmv_row_mac_if #(.DW(DW), .LW(LW), .ACC_W(ACC_W)) if_s ();
  spmv_row_mac_if #(.DW(DW), .LW(LW), .ACC_W(ACC_W)) if_u ();

  assign if_s.len_valid = len_valid;
  assign if_s.len_data  = len_data;
  assign if_s.in_valid  = in_valid;
  assign if_s.in_data   = in_data;
  assign if_s.y_ready   = y_ready;
  assign if_u.len_valid = len_valid;
  assign if_u.len_data  = len_data;
  assign if_u.in_valid  = in_valid;
  assign if_u.in_data   = in_data;
  assign if_u.y_ready   = y_ready;

  spmv_row_mac #(.DW(DW), .LW(LW), .ACC_W(ACC_W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .bus(if_s.slave), .busy(busy_s), .done(done_s)
  );

  spmv_row_mac #(.DW(DW), .LW(LW), .ACC_W(ACC_W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .bus(if_u.slave), .busy(busy_u), .done(done_u)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch_in && (if_s.in_ready || if_u.in_ready)) in_hi++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input int len,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [63:0] es, input logic [63:0] eu,
                         input bit gaps, input int stall, input bit no_in);
    tbl[i].len   = len;
    tbl[i].w[0]  = a;
    tbl[i].w[1]  = b;
    tbl[i].w[2]  = c;
    tbl[i].w[3]  = d;
    tbl[i].exp_s = es;
    tbl[i].exp_u = eu;
    tbl[i].gaps  = gaps;
    tbl[i].stall = stall;
    tbl[i].no_in = no_in;
  endtask

  task automatic apply_start(input int n);
    @(negedge clk);
    start    = 1'b1;
    num_rows = LW'(n);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("start%0d_busy", n), {63'd0, busy_s}, (n != 0) ? 64'd1 : 64'd0);
    check($sformatf("start%0d_done", n), {63'd0, done_s}, (n != 0) ? 64'd0 : 64'd1);
  endtask

  // Presents one word and returns just after the posedge on which it was accepted.
  task automatic apply_stimulus(input bit is_len, input logic [31:0] d, input int gap);
    int waits;
    @(negedge clk);
    len_valid = 1'b0;
    in_valid  = 1'b0;
    if (gap > 0) repeat (gap) @(negedge clk);
    if (is_len) begin
      len_valid = 1'b1;
      len_data  = d[LW-1:0];
    end else begin
      in_valid = 1'b1;
      in_data  = d;
    end
    waits = 0;
    while (!(is_len ? if_s.len_ready : if_s.in_ready) && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL handshake_timeout actual=ready_low required=ready_high");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] es, input logic [63:0] eu,
                              input int row, input int stall);
    int waits;
    @(negedge clk);
    len_valid = 1'b0;
    in_valid  = 1'b0;
    y_ready   = 1'b0;
    waits = 0;
    while (!if_s.y_valid && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_y_timeout actual=0 required=1", tag);
      return;
    end
    // Junk element held during the stall must be ignored outside GET_V/GET_M.
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      check($sformatf("%s_stall%0d_valid", tag, k), {63'd0, if_s.y_valid}, 64'd1);
      check($sformatf("%s_stall%0d_data", tag, k), if_s.y_data, es);
      check($sformatf("%s_stall%0d_row", tag, k), {48'd0, if_s.y_row}, 64'(row));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check($sformatf("%s_y_s", tag), if_s.y_data, es);
    check($sformatf("%s_y_u", tag), if_u.y_data, eu);
    check($sformatf("%s_row", tag), {48'd0, if_s.y_row}, 64'(row));
    check($sformatf("%s_row_u", tag), {48'd0, if_u.y_row}, 64'(row));
    y_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    y_ready = 1'b0;
    check($sformatf("%s_valid_drop", tag), {63'd0, if_s.y_valid}, 64'd0);
  endtask

  task automatic run_row(input int r, input int row);
    string tag;
    tag = $sformatf("r%0d", r);
    in_hi    = 0;
    watch_in = tbl[r].no_in;
    apply_stimulus(1'b1, 32'(tbl[r].len), tbl[r].gaps ? 2 : 0);
    for (int k = 0; k < 2 * tbl[r].len; k++)
      apply_stimulus(1'b0, tbl[r].w[k], tbl[r].gaps ? ((k % 4) + 1) : 0);
    check_output(tag, tbl[r].exp_s, tbl[r].exp_u, row, tbl[r].stall);
    watch_in = 1'b0;
    if (tbl[r].no_in) check($sformatf("%s_in_ready_seen", tag), 64'(in_hi), 64'd0);
  endtask

  initial begin
    int bad;
    // idx len  words                                   signed              unsigned            gaps stall no_in
    set_row(0, 2, 32'd3, 32'd4, 32'd5, 32'd6,            64'd42,             64'd42,             0, 0, 0);
    set_row(1, 1, 32'd7, 32'hFFFF_FFFE, 0, 0,            64'hFFFF_FFFF_FFFF_FFF2, 64'h0000_0006_FFFF_FFF2, 0, 0, 0);
    set_row(2, 0, 0, 0, 0, 0,                            64'd0,              64'd0,              0, 0, 1);
    set_row(3, 1, 32'd9, 32'd9, 0, 0,                    64'd81,             64'd81,             0, 0, 0);
    set_row(4, 0, 0, 0, 0, 0,                            64'd0,              64'd0,              0, 0, 1);
    set_row(5, 2, 32'd3, 32'd4, 32'd5, 32'd6,            64'd42,             64'd42,             1, 5, 0);
    set_row(6, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                                         64'd2,              64'hFFFF_FFFC_0000_0002, 0, 0, 0);
    set_row(7, 1, 32'd2, 32'd3, 0, 0,                    64'd6,              64'd6,              0, 0, 0);
    jobs[0] = '{0, 2};
    jobs[1] = '{2, 3};
    jobs[2] = '{5, 1};
    jobs[3] = '{6, 1};

    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy_s}, 64'd0);
    check("rst_done", {63'd0, done_s}, 64'd0);
    check("rst_len_ready", {63'd0, if_s.len_ready}, 64'd0);
    check("rst_y_valid", {63'd0, if_s.y_valid}, 64'd0);
    reset = 1'b1;

    for (int j = 0; j < 4; j++) begin
      apply_start(jobs[j].n);
      for (int r = 0; r < jobs[j].n; r++) run_row(jobs[j].first + r, r);
      check($sformatf("job%0d_done", j), {63'd0, done_s}, 64'd1);
      check($sformatf("job%0d_busy", j), {63'd0, busy_s}, 64'd0);
      check($sformatf("job%0d_done_u", j), {63'd0, done_u}, 64'd1);
    end

    // Empty job: straight to DONE, nothing requested or emitted.
    apply_start(0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_s.y_valid || if_s.len_ready || busy_s) bad++;
    end
    check("zero_rows_quiet", 64'(bad), 64'd0);
    check("zero_rows_done", {63'd0, done_s}, 64'd1);

    // Reset after the first of three pairs, while the second x is being awaited.
    apply_start(1);
    apply_stimulus(1'b1, 32'd3, 0);
    apply_stimulus(1'b0, 32'd10, 0);
    apply_stimulus(1'b0, 32'd11, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", {63'd0, busy_s}, 64'd0);
    check("mid_rst_done", {63'd0, done_s}, 64'd0);
    check("mid_rst_in_ready", {63'd0, if_s.in_ready}, 64'd0);
    check("mid_rst_len_ready", {63'd0, if_s.len_ready}, 64'd0);
    check("mid_rst_y_valid", {63'd0, if_s.y_valid}, 64'd0);
    check("mid_rst_y_data_s", if_s.y_data, 64'd0);
    check("mid_rst_y_data_u", if_u.y_data, 64'd0);
    check("mid_rst_y_row", {48'd0, if_s.y_row}, 64'd0);
    reset = 1'b1;
    apply_start(1);
    run_row(7, 0);
    check("post_rst_done", {63'd0, done_s}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spmv_row_mac.md
Name: spmv_row_mac

Overview:
- Downstream consumer of the HHT processor-side buffer stream. The HHT frontend delivers, per non-zero, a vector value x[col] followed by a matrix value A[row][col].
- The block multiplies each pair and accumulates per CSR row. A per-row non-zero count (row length) arrives on a separate stream.
- Each completed row emits one result y[row] with its row index. This offloads the SpMV inner loop from the CPU.

Parameters:
DW, 32, data word width of in_data.
LW, 16, width of row counts, row lengths and row index.
ACC_W, 64, accumulator and result width; must be >= 2*DW.
SIGNED, 1, 1 = two's-complement multiply, 0 = unsigned.

Ports:
clk  in  1  clock, all logic on posedge.
reset  in  1  synchronous, active-low.
start  in  1  begin a job; sampled only in IDLE or DONE.
num_rows  in  LW  rows in the job; latched on accepted start.
len_valid  in  1  row-length word valid.
len_ready  out  1  block accepts row length.
len_data  in  LW  non-zeros in the current row.
in_valid  in  1  element word valid.
in_ready  out  1  block accepts element word.
in_data  in  DW  element word, alternating vector value then matrix value.
y_valid  out  1  row result valid.
y_ready  in  1  downstream accepts result.
y_data  out  ACC_W  accumulated dot product of the row.
y_row  out  LW  row index of y_data, 0-based.
busy  out  1  high in every state except IDLE and DONE.
done  out  1  high while in DONE.

Behaviour:
- Reset (reset==0 at posedge), applied in any state including mid-job:
  - state=IDLE; all outputs 0 (len_ready, in_ready, y_valid, y_data, y_row, busy, done).
  - acc, prod, remaining, row counter and latched x all 0.
  - Partial row results are discarded.
- Handshake rule: a transfer occurs on a posedge where valid&&ready. Ready outputs are pure functions of state. Valid inputs must hold data stable until accepted.
- FSM states: IDLE, GET_LEN, GET_V, GET_M, MAC, EMIT, DONE.
- IDLE / DONE:
  - start==1 latches num_rows, clears row counter and acc, and sets y_row=0.
  - If num_rows==0, go to DONE; otherwise go to GET_LEN.
  - start in DONE restarts the job the same way. done drops the cycle after start is accepted.
- GET_LEN:
  - len_ready=1. On transfer: remaining=len_data, acc=0.
  - len_data==0 goes to EMIT with y_data=0; otherwise go to GET_V.
- GET_V: in_ready=1. On transfer, latch x=in_data, then go to GET_M.
- GET_M:
  - in_ready=1. On transfer, prod = x*in_data, full 2*DW bits, sign- or zero-extended to ACC_W per SIGNED.
  - Registered; go to MAC.
- MAC:
  - acc = acc + prod, modulo 2^ACC_W (wrap, no saturation). remaining decrements by 1.
  - If remaining becomes 0, go to EMIT with y_data=acc+prod; otherwise go to GET_V.
- EMIT:
  - y_valid=1; y_data and y_row stay stable while y_valid && !y_ready.
  - On transfer: y_valid=0 and the row counter increments.
  - If the row counter reaches num_rows, go to DONE. Otherwise y_row=row+1 and go to GET_LEN.
- Latency: minimum 3 cycles per non-zero (GET_V, GET_M, MAC). The result is presented the cycle after the last MAC, or after GET_LEN for an empty row.
- Back-pressure: the block never drops or duplicates a word. Stalls of any length on in_valid, len_valid or y_ready are legal in their respective states.
- Words presented outside the owning state are ignored (ready=0), never consumed.
- start while busy is ignored.
- Row counter and y_row wrap modulo 2^LW. num_rows = 2^LW-1 is the maximum job size.
- len_ready and in_ready are never high in the same cycle. At most one handshake completes per cycle.

Test Plan:
- Rows: num_rows=2, lens {2,1}, words {3,4, 5,6} then {7,-2}, SIGNED=1 -> y(row0)=42, y(row1)=-14 (ACC_W two's complement), then done=1, busy=0.
- Empty row: num_rows=3, lens {0,1,0}, words {9,9} -> y sequence 0, 81, 0 with y_row 0, 1, 2; in_ready never 1 during rows 0 and 2.
- Zero rows: start with num_rows=0 -> done=1 on the next cycle, no y_valid, len_ready stays 0.
- Back-pressure: hold y_ready=0 for 5 cycles on row0=42 -> y_data/y_row stay stable and y_valid stays high. Insert in_valid gaps of 1-4 cycles -> same results as with no gaps.
- Wrap/unsigned: SIGNED=0, DW=32, one row len=2, words {FFFFFFFF,FFFFFFFF} twice -> y = 2*(FFFFFFFE00000001) mod 2^64 = FFFFFFFC00000002.
- Reset mid-row: after 1 of 3 pairs is accepted, pulse reset -> all outputs 0 and state IDLE. A new start with num_rows=1, len 1, {2,3} -> y=6, y_row=0 (no residue).
